// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory controller: access widths, IO region code, FSM states.
package mem_pkg;

  localparam logic [1:0] W_BYTE = 2'd0;
  localparam logic [1:0] W_HALF = 2'd1;
  localparam logic [1:0] W_WORD = 2'd2;

  localparam logic [1:0] IO_REGION_HI = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RD_LAST,
    WR,
    DONE
  } state_t;

  // Width code 3 is handled as a word access.
  function automatic logic [2:0] beat_count(input logic [1:0] width);
    case (width)
      W_BYTE:  return 3'd1;
      W_HALF:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Zero/sign extension of reassembled load data to 32 bits.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  width,
  input  logic        sign_ext,
  output logic [31:0] val
);

  always_comb begin
    case (width)
      W_BYTE:  val = {{24{sign_ext & raw[7]}}, raw[7:0]};
      W_HALF:  val = {{16{sign_ext & raw[15]}}, raw[15:0]};
      default: val = raw;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Byte-serial data-memory controller between the LSB and the shared 8-bit RAM port.
// Optional DMEM_LAST_BYTE_BYPASS_EN: final load byte is forwarded combinationally, skipping RD_LAST.
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 18,
  parameter logic [1:0]  IO_HI  = IO_REGION_HI
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dcache_rw_en,
  input  logic              dcache_write_mode,
  input  logic [1:0]        dcache_width,
  input  logic              dcache_sign_ext,
  input  logic [ADDR_W-1:0] dcache_addr,
  input  logic [31:0]       dcache_value,
  output logic              dcache_idle,
  output logic              dcache_rw_feedback_en,
  output logic [31:0]       dcache_load_val,
  output logic              mem_req,
  input  logic              mem_grant,
  output logic [31:0]       mem_a,
  output logic              mem_wr,
  output logic [7:0]        mem_dout,
  input  logic [7:0]        mem_din,
  input  logic              io_buffer_full
);

  state_t state, state_next;

  logic [ADDR_W-1:0] addr;
  logic [1:0]        width;
  logic              sign_ext;
  logic              is_write;
  logic [31:0]       value;
  logic [31:0]       raw;
  logic [31:0]       load_reg;
  logic [2:0]        k;
  logic              pend;
  logic [1:0]        pend_lane;

  logic              accept;
  logic              beat;
  logic              last_beat;
  logic              io_block;
  logic [ADDR_W-1:0] beat_addr;
  logic [31:0]       raw_final;
  logic [31:0]       ext_val;

  assign last_beat = (k == beat_count(width) - 3'd1);
  assign beat_addr = addr + ADDR_W'(k);
  assign io_block  = is_write && (addr[ADDR_W-1 -: 2] == IO_HI) && io_buffer_full;

  // Lanes already captured, with the byte currently on mem_din merged into the pending lane.
  always_comb begin
    raw_final = raw;
    raw_final[{pend_lane, 3'b000} +: 8] = mem_din;
  end

  load_extend u_load_extend (
    .raw      (raw_final),
    .width    (width),
    .sign_ext (sign_ext),
    .val      (ext_val)
  );

  always_comb begin
    state_next            = state;
    accept                = 1'b0;
    beat                  = 1'b0;
    dcache_idle           = 1'b0;
    dcache_rw_feedback_en = 1'b0;
    mem_req               = 1'b0;
    mem_wr                = 1'b0;
    mem_a                 = '0;
    mem_dout              = '0;
    case (state)
      IDLE, DONE: begin
        dcache_idle           = 1'b1;
        dcache_rw_feedback_en = (state == DONE);
        accept                = dcache_rw_en;
        if (dcache_rw_en) state_next = dcache_write_mode ? WR : RD;
        else              state_next = IDLE;
      end
      RD: begin
        mem_req = 1'b1;
        mem_a   = 32'(beat_addr);
        if (mem_grant) begin
          beat = 1'b1;
`ifdef DMEM_LAST_BYTE_BYPASS_EN
          if (last_beat) state_next = DONE;
`else
          if (last_beat) state_next = RD_LAST;
`endif
        end
      end
      RD_LAST: state_next = DONE;
      WR: begin
        mem_req  = 1'b1;
        mem_a    = 32'(beat_addr);
        mem_dout = value[{k[1:0], 3'b000} +: 8];
        if (mem_grant && !io_block) begin
          beat   = 1'b1;
          mem_wr = 1'b1;
          if (last_beat) state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef DMEM_LAST_BYTE_BYPASS_EN
  assign dcache_load_val = (state == DONE && !is_write) ? ext_val : load_reg;
`else
  assign dcache_load_val = load_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      width     <= '0;
      sign_ext  <= 1'b0;
      is_write  <= 1'b0;
      value     <= '0;
      raw       <= '0;
      load_reg  <= '0;
      k         <= '0;
      pend      <= 1'b0;
      pend_lane <= '0;
    end else begin
      state <= state_next;
`ifdef DMEM_LAST_BYTE_BYPASS_EN
      if (state == DONE && !is_write) load_reg <= ext_val;
`else
      if (state == RD_LAST) load_reg <= ext_val;
`endif
      if (accept) begin
        addr     <= dcache_addr;
        width    <= dcache_width;
        sign_ext <= dcache_sign_ext;
        is_write <= dcache_write_mode;
        value    <= dcache_value;
        raw      <= '0;
        k        <= '0;
        pend     <= 1'b0;
      end else begin
        // Read data trails its granted beat by one cycle.
        if (pend) raw[{pend_lane, 3'b000} +: 8] <= mem_din;
        pend <= beat && !is_write;
        if (beat) begin
          k         <= k + 3'd1;
          pend_lane <= k[1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: transaction-level queue model plus directed literal checks.
module tb_data_mem_ctrl;

`ifdef DMEM_LAST_BYTE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        dcache_rw_en, dcache_write_mode, dcache_sign_ext;
  logic [1:0]  dcache_width;
  logic [17:0] dcache_addr;
  logic [31:0] dcache_value;
  logic        dcache_idle, dcache_rw_feedback_en;
  logic [31:0] dcache_load_val;
  logic        mem_req, mem_grant, mem_wr, io_buffer_full;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout, mem_din;

  data_mem_ctrl #(.ADDR_W(18), .IO_HI(2'b11)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .dcache_rw_en          (dcache_rw_en),
    .dcache_write_mode     (dcache_write_mode),
    .dcache_width          (dcache_width),
    .dcache_sign_ext       (dcache_sign_ext),
    .dcache_addr           (dcache_addr),
    .dcache_value          (dcache_value),
    .dcache_idle           (dcache_idle),
    .dcache_rw_feedback_en (dcache_rw_feedback_en),
    .dcache_load_val       (dcache_load_val),
    .mem_req               (mem_req),
    .mem_grant             (mem_grant),
    .mem_a                 (mem_a),
    .mem_wr                (mem_wr),
    .mem_dout              (mem_dout),
    .mem_din               (mem_din),
    .io_buffer_full        (io_buffer_full)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void chk(string name, logic [31:0] got, logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h, required %h (t=%0t)", name, got, want, $time);
  endfunction

  function automatic void fail_timeout(string name);
    n_checks++;
    $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
  endfunction

  // RAM: read data appears the cycle after a granted address.
  logic [7:0]  ram [0:262143];
  logic        poke_en = 1'b0;
  logic [17:0] poke_a  = '0;
  logic [7:0]  poke_d  = '0;

  always @(posedge clk) begin
    if (poke_en) ram[poke_a] <= poke_d;
    if (mem_req === 1'b1 && mem_grant === 1'b1) begin
      if (mem_wr === 1'b1) ram[mem_a[17:0]] <= mem_dout;
      mem_din <= ram[mem_a[17:0]];
    end else begin
      mem_din <= 8'($urandom);
    end
  end

  // Reference model: each accepted request becomes a queue of byte beats.
  logic [7:0]  ref_mem [0:262143];
  logic [17:0] mq_a [$];
  logic [7:0]  mq_d [$];
  bit          m_tail = 1'b0, m_fb = 1'b0, m_wr = 1'b0, m_io = 1'b0;
  logic [31:0] m_load_exp = '0, m_last_load = '0;

  function automatic bit model_idle();
    return (mq_a.size() == 0) && !m_tail;
  endfunction

  function automatic logic [31:0] extend(logic [31:0] v, logic [1:0] w, bit sx);
    logic [31:0] r;
    r = v;
    if (w == 2'd0) begin
      r = v % 256;
      if (sx && r >= 128) r = r + 32'hFFFF_FF00;
    end else if (w == 2'd1) begin
      r = v % 65536;
      if (sx && r >= 32768) r = r + 32'hFFFF_0000;
    end
    return r;
  endfunction

  always @(negedge clk) begin : compare
    bit          idle_e, req_e, blk, fb_next;
    logic [31:0] lv_e, acc;
    int          n;
    idle_e = model_idle();
    req_e  = (mq_a.size() != 0);
    blk    = m_wr && m_io && (io_buffer_full === 1'b1);
    lv_e   = (m_fb && !m_wr) ? m_load_exp : m_last_load;
    chk("idle", 32'(dcache_idle), 32'(idle_e));
    chk("feedback", 32'(dcache_rw_feedback_en), 32'(m_fb));
    chk("mem_req", 32'(mem_req), 32'(req_e));
    chk("mem_wr", 32'(mem_wr), 32'(req_e && m_wr && mem_grant && !blk));
    chk("load_val", dcache_load_val, lv_e);
    if (req_e) begin
      chk("mem_a", mem_a, 32'(mq_a[0]));
      if (m_wr) chk("mem_dout", 32'(mem_dout), 32'(mq_d[0]));
    end

    if (poke_en) ref_mem[poke_a] = poke_d;
    if (rst) begin
      mq_a.delete();
      mq_d.delete();
      m_tail = 1'b0;
      m_fb = 1'b0;
      m_last_load = '0;
    end else begin
      if (m_fb && !m_wr) m_last_load = m_load_exp;
      fb_next = m_tail;
      m_tail = 1'b0;
      if (req_e && mem_grant && !blk) begin
        void'(mq_a.pop_front());
        void'(mq_d.pop_front());
        if (mq_a.size() == 0) begin
          if (m_wr || BYP) fb_next = 1'b1;
          else             m_tail = 1'b1;
        end
      end
      if (idle_e && dcache_rw_en) begin
        n    = (dcache_width == 2'd0) ? 1 : (dcache_width == 2'd1) ? 2 : 4;
        m_wr = dcache_write_mode;
        m_io = (dcache_addr[17:16] == 2'b11);
        acc  = '0;
        for (int i = 0; i < n; i++) begin
          logic [17:0] a;
          a = dcache_addr + 18'(i);
          mq_a.push_back(a);
          mq_d.push_back(dcache_value[8*i +: 8]);
          if (dcache_write_mode) ref_mem[a] = dcache_value[8*i +: 8];
          else acc = acc | (32'(ref_mem[a]) << (8*i));
        end
        m_load_exp = extend(acc, dcache_width, dcache_sign_ext);
      end
      m_fb = fb_next;
    end
  end

  // Stimulus
  int grant_mode = 0, io_mode = 0, io_cnt = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    case (grant_mode)
      0:       mem_grant = 1'b1;
      1:       mem_grant = ~mem_grant;
      default: mem_grant = ($urandom_range(0, 3) != 0);
    endcase
    if (io_mode == 2) io_buffer_full = ($urandom_range(0, 2) == 0);
    else begin
      io_buffer_full = (io_cnt > 0);
      if (io_cnt > 0) io_cnt--;
    end
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    tick();
    while (!model_idle() && g < 300) begin
      tick();
      g++;
    end
    if (g >= 300) fail_timeout("wait_idle");
  endtask

  task automatic poke(input logic [17:0] a, input logic [7:0] d);
    tick();
    poke_en = 1'b1;
    poke_a  = a;
    poke_d  = d;
  endtask

  task automatic do_req(input bit wr, input logic [1:0] w, input bit sx, input logic [17:0] a,
                        input logic [31:0] v, input int io_cyc, output int lat, output logic [31:0] lv);
    wait_idle();
    dcache_rw_en      = 1'b1;
    dcache_write_mode = wr;
    dcache_width      = w;
    dcache_sign_ext   = sx;
    dcache_addr       = a;
    dcache_value      = v;
    io_cnt            = io_cyc;
    io_buffer_full    = 1'b0;
    lat = -1;
    lv  = '0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (c > 0 && dcache_rw_feedback_en === 1'b1) begin
        lat = c;
        lv  = dcache_load_val;
        break;
      end
      tick();
      dcache_rw_en = 1'b0;
    end
    if (lat < 0) fail_timeout("feedback");
  endtask

  initial begin : main
    int          lat, g;
    logic [31:0] lv;
    logic [17:0] a;
    rst = 1'b1;
    dcache_rw_en = 1'b0; dcache_write_mode = 1'b0; dcache_width = '0; dcache_sign_ext = 1'b0;
    dcache_addr = '0; dcache_value = '0; mem_grant = 1'b1; io_buffer_full = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_idle", 32'(dcache_idle), 32'd1);
    chk("rst_fb", 32'(dcache_rw_feedback_en), 32'd0);
    chk("rst_load_val", dcache_load_val, 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_dout", 32'(mem_dout), 32'd0);

    for (int i = 0; i < 64; i++) begin
      poke(18'(i), 8'($urandom));
      poke(18'h3FFC0 + 18'(i), 8'($urandom));
      poke(18'h30000 + 18'(i), 8'($urandom));
    end
    poke(18'h100, 8'h11); poke(18'h101, 8'h22); poke(18'h102, 8'h33); poke(18'h103, 8'h44);
    poke(18'h003, 8'h80); poke(18'h010, 8'hFF); poke(18'h011, 8'h7F);
    tick();
    poke_en = 1'b0;
    rst = 1'b0;

    do_req(1'b0, 2'd2, 1'b0, 18'h00100, 32'h0, 0, lat, lv);
    chk("word_load_lat", 32'(lat), BYP ? 32'd5 : 32'd6);
    chk("word_load_val", lv, 32'h4433_2211);
    do_req(1'b0, 2'd0, 1'b1, 18'h00003, 32'h0, 0, lat, lv);
    chk("byte_signed", lv, 32'hFFFF_FF80);
    chk("byte_load_lat", 32'(lat), BYP ? 32'd2 : 32'd3);
    do_req(1'b0, 2'd0, 1'b0, 18'h00003, 32'h0, 0, lat, lv);
    chk("byte_unsigned", lv, 32'h0000_0080);
    do_req(1'b0, 2'd1, 1'b1, 18'h00010, 32'h0, 0, lat, lv);
    chk("half_signed", lv, 32'h0000_7FFF);

    do_req(1'b1, 2'd1, 1'b0, 18'h3FFFF, 32'hABCD_1234, 0, lat, lv);
    chk("half_store_lat", 32'(lat), 32'd3);
    chk("wrap_byte0", 32'(ram[18'h3FFFF]), 32'h34);
    chk("wrap_byte1", 32'(ram[18'h00000]), 32'h12);

    do_req(1'b1, 2'd0, 1'b0, 18'h30000, 32'h0000_005A, 3, lat, lv);
    chk("io_store_lat", 32'(lat), 32'd5);
    chk("io_store_data", 32'(ram[18'h30000]), 32'h5A);

    grant_mode = 1;
    do_req(1'b0, 2'd2, 1'b0, 18'h00100, 32'h0, 0, lat, lv);
    chk("toggle_load_val", lv, 32'h4433_2211);
    grant_mode = 0;

    // Store accepted in the load's feedback cycle
    wait_idle();
    dcache_rw_en = 1'b1; dcache_write_mode = 1'b0; dcache_width = 2'd0;
    dcache_sign_ext = 1'b0; dcache_addr = 18'h00003;
    tick();
    dcache_rw_en = 1'b0;
    g = 0;
    while (!m_fb && g < 50) begin
      tick();
      g++;
    end
    if (g >= 50) fail_timeout("b2b_fb");
    dcache_rw_en = 1'b1; dcache_write_mode = 1'b1; dcache_addr = 18'h00020; dcache_value = 32'h77;
    @(negedge clk);
    chk("b2b_fb", 32'(dcache_rw_feedback_en), 32'd1);
    chk("b2b_load_val", dcache_load_val, 32'h80);
    tick();
    dcache_rw_en = 1'b0;
    @(negedge clk);
    chk("b2b_first_wr", 32'(mem_wr), 32'd1);
    chk("b2b_first_a", mem_a, 32'h20);
    wait_idle();
    chk("b2b_store_data", 32'(ram[18'h00020]), 32'h77);

    // Reset in the middle of a load
    dcache_rw_en = 1'b1; dcache_write_mode = 1'b0; dcache_width = 2'd2; dcache_addr = 18'h00100;
    tick();
    dcache_rw_en = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_idle", 32'(dcache_idle), 32'd1);
    chk("rst_mid_fb", 32'(dcache_rw_feedback_en), 32'd0);
    repeat (6) tick();

    grant_mode = 2;
    io_mode    = 2;
    for (int i = 0; i < 250; i++) begin
      wait_idle();
      case ($urandom_range(0, 2))
        0:       a = 18'($urandom_range(0, 60));
        1:       a = 18'h3FFC0 + 18'($urandom_range(0, 63));
        default: a = 18'h30000 + 18'($urandom_range(0, 60));
      endcase
      dcache_rw_en      = 1'b1;
      dcache_write_mode = 1'($urandom_range(0, 1));
      dcache_width      = 2'($urandom_range(0, 3));
      dcache_sign_ext   = 1'($urandom_range(0, 1));
      dcache_addr       = a;
      dcache_value      = $urandom;
      tick();
      dcache_rw_en = 1'b0;
    end
    wait_idle();
    grant_mode = 0;
    io_mode    = 0;
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Byte-serial data-memory controller directly downstream of the load/store buffer (LSB).
- Accepts one load/store request at a time over the LSB's dcache request interface.
- Splits each request into 1/2/4 byte transactions on the shared 8-bit RAM port, reassembles and extends load data, and returns a single-cycle completion pulse.
- Port access is granted per cycle by the top-level memory arbiter, which is shared with instruction fetch.

Parameters:
- ADDR_W, 18, width of the data address from the LSB.
- IO_HI, 2'b11, value of addr[17:16] that marks the memory-mapped IO region.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- dcache_rw_en  input  1  request valid
- dcache_write_mode  input  1  1 = store, 0 = load
- dcache_width  input  2  0 = byte, 1 = half, 2 = word, 3 = treated as word
- dcache_sign_ext  input  1  load sign-extend flag
- dcache_addr  input  18  byte address
- dcache_value  input  32  store data
- dcache_idle  output  1  controller can accept a request
- dcache_rw_feedback_en  output  1  one-cycle completion pulse
- dcache_load_val  output  32  extended load result, valid with feedback
- mem_req  output  1  controller wants the RAM port this cycle
- mem_grant  input  1  arbiter grants the port this cycle
- mem_a  output  32  RAM byte address, {14'b0, addr}
- mem_wr  output  1  RAM write strobe
- mem_dout  output  8  RAM write byte
- mem_din  input  8  RAM read byte, valid the cycle after its address was granted
- io_buffer_full  input  1  UART buffer full; IO stores must wait

Behaviour:
- States: IDLE, RD, RD_LAST, WR, DONE.
- Reset values:
  - State = IDLE.
  - dcache_idle = 1; dcache_rw_feedback_en = 0; dcache_load_val = 0.
  - mem_req = 0; mem_wr = 0; mem_a = 0; mem_dout = 0.
- Reset in any state aborts the transaction immediately. No feedback is issued.
- Request acceptance:
  - A request is accepted when dcache_rw_en = 1 in IDLE or DONE.
  - Address, width, sign_ext and value are latched; byte counter k = 0; N = 1/2/4.
  - In DONE, a new request may be accepted in the same cycle as the feedback pulse (back-to-back).
- dcache_idle = 1 in IDLE and DONE, 0 otherwise. It is 1 during the feedback cycle, so the LSB's reset path never waits on a phantom completion.
- Beat issue:
  - A beat is issued only in a cycle with mem_grant = 1.
  - For k < N, the beat drives mem_a = {14'b0, addr + k}; the address sum wraps modulo 2^18.
  - mem_req = 1 while beats remain.
  - An ungranted cycle holds k and drives mem_wr = 0.
- RD:
  - Beat k is issued with mem_wr = 0.
  - The byte returned on mem_din in the next clock cycle is latched into lane k (little-endian).
  - After the last beat is issued: RD_LAST. The final byte is captured there, then DONE.
- WR:
  - Beat k drives mem_wr = 1 and mem_dout = value[8k+7:8k].
  - When addr[17:16] == IO_HI and io_buffer_full = 1, the beat is withheld: mem_wr = 0, k held, mem_req still 1.
  - After the last beat: DONE.
- DONE: dcache_rw_feedback_en = 1 for exactly one cycle, then IDLE (or the new request's first state).
- Load extension:
  - byte: sign_ext ? {24{b[7]}} : 24'b0 above b.
  - half: same rule with bit 15.
  - word: passes through.
- Latency with continuous grant, from acceptance cycle A:
  - Store: feedback at A+N+1.
  - Load: feedback at A+N+2.
- dcache_load_val holds its value after feedback until the next load completes. For stores it is don't-care.
- Requests arriving while not idle are ignored; the LSB guarantees they do not occur.

Optional Feature:
- DMEM_LAST_BYTE_BYPASS_EN
  - Defined: RD_LAST is skipped. On the cycle the final byte arrives, feedback is asserted and dcache_load_val is formed combinationally from mem_din plus the latched lanes. Load latency becomes A+N+1.
  - Undefined: registered path as above.

Decomposition:
- Shared package mem_pkg:
  - Width encodings: W_BYTE / W_HALF / W_WORD.
  - IO_HI region code.
  - State enum.
- One combinational sub-module: load_extend, taking (raw[31:0], width, sign_ext) and producing the extended value.

Test Plan:
- Word load, addr 0x00100, RAM bytes 11 22 33 44, grant always 1 -> feedback at A+6, load_val 0x44332211; with DMEM_LAST_BYTE_BYPASS_EN, at A+5.
- Signed byte load of 0x80 at 0x00003 -> 0xFFFFFF80; unsigned -> 0x00000080; signed half 0x7FFF -> 0x00007FFF.
- Half store 0xABCD1234 to 0x3FFFF -> writes 0x34 at 0x3FFFF, then 0x12 at 0x00000 (wrap); feedback at A+3.
- IO byte store to 0x30000 with io_buffer_full high for 3 cycles -> mem_wr stays 0 for those 3 cycles, then one write; feedback the next cycle; dcache_idle low throughout.
- mem_grant toggling 1,0,1,0 during a word load -> beats issue only on granted cycles; data still correct; feedback follows the last captured byte.
- Back-to-back: a new store is accepted in the DONE cycle of a load -> first store beat in the next granted cycle; rst asserted mid-load -> next cycle idle = 1, no feedback.
